// File: rtl/ats21_pkg.sv
// ---------------------------------------------------------------------------
// ats21_pkg
// Shared definitions for the ATS21 host-interface command receiver:
//   - opcode_t   : 3-bit instruction opcodes (word bits [31:29])
//   - rx_state_t : receive/decode FSM states
//   - bit positions of the instruction fields and of the stat response bits
//   - op_is_clock() / op_is_alarm() : resource class of an opcode
// ---------------------------------------------------------------------------
package ats21_pkg;

    localparam int N_CLOCKS   = 16;
    localparam int N_ALARMS   = 32;
    localparam int CLK_ID_W   = $clog2(N_CLOCKS);
    localparam int ALARM_ID_W = $clog2(N_ALARMS);

    typedef enum logic [2:0] {
        OP_NOP           = 3'b000,
        OP_SET_CLOCK     = 3'b001,
        OP_CLK_TOGGLE    = 3'b010,
        OP_SET_MODE      = 3'b011,
        OP_RESERVED      = 3'b100,
        OP_SET_ALARM     = 3'b101,
        OP_SET_COUNTDOWN = 3'b110,
        OP_AT_TOGGLE     = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UPPER  = 3'd1,
        ST_LOWER  = 3'd2,
        ST_DECODE = 3'd3,
        ST_RESP   = 3'd4
    } rx_state_t;

    // Instruction field positions within the 32-bit {upper,lower} word
    localparam int OP_MSB         = 31;
    localparam int OP_LSB         = 29;
    localparam int ID_MSB         = 28;
    localparam int CLK_ID_LSB     = ID_MSB - CLK_ID_W + 1;
    localparam int ALARM_ID_LSB   = ID_MSB - ALARM_ID_W + 1;
    localparam int RATE_MSB       = 23;
    localparam int RATE_LSB       = 22;
    localparam int MODE_ACT_BIT   = 28;
    localparam int MODE_AT_MSB    = 27;
    localparam int MODE_AT_LSB    = 26;
    localparam int MODE_BC_MSB    = 25;
    localparam int MODE_BC_LSB    = 24;

    localparam logic [1:0] RATE_RESERVED = 2'b11;

    // Permission registers are packed {A,B}
    localparam int PERM_A_BIT = 1;
    localparam int PERM_B_BIT = 0;

    // Response status bits
    localparam int STAT_A_BIT = 0;
    localparam int STAT_B_BIT = 1;

    function automatic logic op_is_clock(input logic [2:0] op);
        return (op == OP_SET_CLOCK) || (op == OP_CLK_TOGGLE);
    endfunction

    function automatic logic op_is_alarm(input logic [2:0] op);
        return (op == OP_SET_ALARM) || (op == OP_SET_COUNTDOWN) ||
               (op == OP_AT_TOGGLE);
    endfunction

endpackage

// File: rtl/ats21_cmd_check.sv
// ---------------------------------------------------------------------------
// ats21_cmd_check
// Combinational validation of one client's instruction against the opcode
// map and the current mode/permission state. A/B conflict resolution is done
// by the parent, which is why the resource class and id are exported.
// Ports:
//   cmd_hi_i      : instruction bits [31:22] (opcode, resource id, rate)
//   mode_active_i : current ATS21 active bit
//   at_perm_i     : this client's alarm/timer permission bit
//   bc_perm_i     : this client's clock permission bit
//   is_client_b_i : tie high for client B (B may not change the mode)
//   reject_o      : instruction fails one of the per-client checks
//   issue_o       : instruction accepted and is not a Nop
//   is_clock_o    : opcode targets a base clock
//   is_alarm_o    : opcode targets an alarm/timer slot
//   res_id_o      : raw id field [28:24]
// ---------------------------------------------------------------------------
module ats21_cmd_check
    import ats21_pkg::*;
(
    input  logic                  [9:0] cmd_hi_i,
    input  logic                        mode_active_i,
    input  logic                        at_perm_i,
    input  logic                        bc_perm_i,
    input  logic                        is_client_b_i,
    output logic                        reject_o,
    output logic                        issue_o,
    output logic                        is_clock_o,
    output logic                        is_alarm_o,
    output logic [ALARM_ID_W-1:0]       res_id_o
);

    localparam int HI_LSB = RATE_LSB;

    logic [2:0] op;
    logic [1:0] rate;

    assign op         = cmd_hi_i[OP_MSB-HI_LSB : OP_LSB-HI_LSB];
    assign rate       = cmd_hi_i[RATE_MSB-HI_LSB : RATE_LSB-HI_LSB];
    assign res_id_o   = cmd_hi_i[ID_MSB-HI_LSB : ALARM_ID_LSB-HI_LSB];
    assign is_clock_o = op_is_clock(op);
    assign is_alarm_o = op_is_alarm(op);

    // Checks are prioritised; a Nop is never an error, even when inactive.
    always_comb begin
        reject_o = 1'b0;
        if (op == OP_NOP) begin
            reject_o = 1'b0;
        end else if ((op == OP_RESERVED) ||
                     ((op == OP_SET_CLOCK) && (rate == RATE_RESERVED))) begin
            reject_o = 1'b1;
        end else if (!mode_active_i && (op != OP_SET_MODE)) begin
            reject_o = 1'b1;
        end else if (op_is_clock(op) && !bc_perm_i) begin
            reject_o = 1'b1;
        end else if (op_is_alarm(op) && !at_perm_i) begin
            reject_o = 1'b1;
        end else if ((op == OP_SET_MODE) && is_client_b_i) begin
            reject_o = 1'b1;
        end
        issue_o = !reject_o && (op != OP_NOP);
    end

endmodule

// File: rtl/ats21_cmd_rx.sv
// ---------------------------------------------------------------------------
// ats21_cmd_rx
// Command receiver/decoder at the ATS21 host interface. After a one-cycle
// req pulse it captures the upper then lower 16-bit words from clients A and
// B, validates both instructions, resolves A/B resource conflicts (A wins),
// updates the mode register for an accepted A set-mode and produces a
// one-cycle ready/stat response together with the issue strobes.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   req                 : instruction request strobe (1 cycle)
//   ctrlA, ctrlB        : client instruction words (upper, then lower)
//   ready, stat         : response strobe and {B rejected, A rejected}
//   exe_valid_a/_b      : issue strobes for accepted non-Nop commands
//   exe_op_a/_b         : opcode of the last decoded instruction
//   exe_word_a/_b       : last decoded full instruction {upper,lower}
//   mode_active         : ATS21 active bit
//   mode_at_perm        : alarm/timer change permission {A,B}
//   mode_bc_perm        : clock change permission {A,B}
// ---------------------------------------------------------------------------
module ats21_cmd_rx
    import ats21_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] ctrlA,
    input  logic [15:0] ctrlB,
    output logic        ready,
    output logic [1:0]  stat,
    output logic        exe_valid_a,
    output logic        exe_valid_b,
    output logic [2:0]  exe_op_a,
    output logic [2:0]  exe_op_b,
    output logic [31:0] exe_word_a,
    output logic [31:0] exe_word_b,
    output logic        mode_active,
    output logic [1:0]  mode_at_perm,
    output logic [1:0]  mode_bc_perm
);

    rx_state_t   state_q, state_d;

    logic [31:0] wordA_q, wordB_q;
    logic [31:0] exeWordA_q, exeWordB_q;
    logic [2:0]  exeOpA_q, exeOpB_q;
    logic        rejA_q, rejB_q, issueA_q, issueB_q;

    logic        modeActive_q, modeActive_d;
    logic [1:0]  modeAtPerm_q, modeAtPerm_d;
    logic [1:0]  modeBcPerm_q, modeBcPerm_d;

    logic                  rejectA, rejectB, issueA, issueB;
    logic                  isClockA, isClockB, isAlarmA, isAlarmB;
    logic [ALARM_ID_W-1:0] resIdA, resIdB;
    logic                  conflict, rejB, issueBFinal;

    ats21_cmd_check u_checkA (
        .cmd_hi_i      (wordA_q[OP_MSB:RATE_LSB]),
        .mode_active_i (modeActive_q),
        .at_perm_i     (modeAtPerm_q[PERM_A_BIT]),
        .bc_perm_i     (modeBcPerm_q[PERM_A_BIT]),
        .is_client_b_i (1'b0),
        .reject_o      (rejectA),
        .issue_o       (issueA),
        .is_clock_o    (isClockA),
        .is_alarm_o    (isAlarmA),
        .res_id_o      (resIdA)
    );

    ats21_cmd_check u_checkB (
        .cmd_hi_i      (wordB_q[OP_MSB:RATE_LSB]),
        .mode_active_i (modeActive_q),
        .at_perm_i     (modeAtPerm_q[PERM_B_BIT]),
        .bc_perm_i     (modeBcPerm_q[PERM_B_BIT]),
        .is_client_b_i (1'b1),
        .reject_o      (rejectB),
        .issue_o       (issueB),
        .is_clock_o    (isClockB),
        .is_alarm_o    (isAlarmB),
        .res_id_o      (resIdB)
    );

    // Clock ids are the upper CLK_ID_W bits of the shared id field; alarm ids
    // use the whole field. B loses only if both sides survived their own checks.
    always_comb begin
        conflict = !rejectA && !rejectB &&
                   ((isClockA && isClockB &&
                     (resIdA[ALARM_ID_W-1 -: CLK_ID_W] == resIdB[ALARM_ID_W-1 -: CLK_ID_W])) ||
                    (isAlarmA && isAlarmB && (resIdA == resIdB)));
        rejB        = rejectB || conflict;
        issueBFinal = issueB && !conflict;
    end

    // Mode register next value: loaded from A's accepted set-mode at the end
    // of DECODE, so the checks of that same instruction see the old mode.
    always_comb begin
        modeActive_d = modeActive_q;
        modeAtPerm_d = modeAtPerm_q;
        modeBcPerm_d = modeBcPerm_q;
        if ((state_q == ST_DECODE) && issueA &&
            (wordA_q[OP_MSB:OP_LSB] == OP_SET_MODE)) begin
            modeActive_d = wordA_q[MODE_ACT_BIT];
            modeAtPerm_d = wordA_q[MODE_AT_MSB:MODE_AT_LSB];
            modeBcPerm_d = wordA_q[MODE_BC_MSB:MODE_BC_LSB];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: req is only looked at in IDLE, so a req arriving
    // mid-transaction is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = ST_UPPER;
            ST_UPPER:  state_d = ST_LOWER;
            ST_LOWER:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the response is presented only during RESP
    always_comb begin
        ready       = 1'b0;
        stat        = 2'b00;
        exe_valid_a = 1'b0;
        exe_valid_b = 1'b0;
        if (state_q == ST_RESP) begin
            ready            = 1'b1;
            stat[STAT_A_BIT] = rejA_q;
            stat[STAT_B_BIT] = rejB_q;
            exe_valid_a      = issueA_q;
            exe_valid_b      = issueB_q;
        end
    end

    // Datapath: word capture, decode results and mode register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wordA_q      <= '0;
            wordB_q      <= '0;
            exeWordA_q   <= '0;
            exeWordB_q   <= '0;
            exeOpA_q     <= '0;
            exeOpB_q     <= '0;
            rejA_q       <= 1'b0;
            rejB_q       <= 1'b0;
            issueA_q     <= 1'b0;
            issueB_q     <= 1'b0;
            modeActive_q <= 1'b1;
            modeAtPerm_q <= 2'b11;
            modeBcPerm_q <= 2'b11;
        end else begin
            modeActive_q <= modeActive_d;
            modeAtPerm_q <= modeAtPerm_d;
            modeBcPerm_q <= modeBcPerm_d;
            case (state_q)
                ST_UPPER: begin
                    wordA_q[31:16] <= ctrlA;
                    wordB_q[31:16] <= ctrlB;
                end
                ST_LOWER: begin
                    wordA_q[15:0] <= ctrlA;
                    wordB_q[15:0] <= ctrlB;
                end
                ST_DECODE: begin
                    exeWordA_q <= wordA_q;
                    exeWordB_q <= wordB_q;
                    exeOpA_q   <= wordA_q[OP_MSB:OP_LSB];
                    exeOpB_q   <= wordB_q[OP_MSB:OP_LSB];
                    rejA_q     <= rejectA;
                    rejB_q     <= rejB;
                    issueA_q   <= issueA;
                    issueB_q   <= issueBFinal;
                end
                default: ;
            endcase
        end
    end

    assign exe_op_a     = exeOpA_q;
    assign exe_op_b     = exeOpB_q;
    assign exe_word_a   = exeWordA_q;
    assign exe_word_b   = exeWordB_q;
    assign mode_active  = modeActive_q;
    assign mode_at_perm = modeAtPerm_q;
    assign mode_bc_perm = modeBcPerm_q;

endmodule
